fut_inv_state_reg: RTL and testbench

Decryption-side 64-bit state/key register for the FUTURE cipher datapath. It undoes the forward register's transforms: rotate-right by 16, rotate-right by 5, and inverse ShiftRows on the 4×4 nibble matrix. It also runs a multi-cycle REWIND that walks a key register back N key-schedule steps, so round keys can be produced in reverse order. Commands arrive from the decryption round controller over a valid/ready handshake, and each completion is reported with a one-cycle `done` pulse.

---
 rtl/fut_pkg.sv | 54 +++++
 rtl/fut_inv_state_reg_if.sv | 27 ++
 rtl/fut_inv_shift_rows.sv | 18 +
 rtl/fut_inv_state_reg.sv | 113 +++++++++++
 tb/tb_fut_inv_state_reg.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fut_pkg.sv
// Shared definitions for the FUTURE cipher state/key registers.
// Holds the datapath width, command opcodes, FSM state type, the nibble
// permutation tables used by the encrypt and decrypt sides, and the
// fixed-amount rotation helpers.
package fut_pkg;

  localparam int FUT_W   = 64;
  localparam int FUT_NIB = 16;

  // Command opcodes. Encodings 6 and 7 are reserved and treated as NOP.
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_ROR16  = 3'd2,
    OP_ROR5   = 3'd3,
    OP_INV_SR = 3'd4,
    OP_REWIND = 3'd5
  } fut_op_e;

  // Two-state controller: single-cycle ops complete in IDLE, REWIND walks in BUSY.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fut_state_e;

  // Nibble permutation tables: entry k names the source nibble that lands in
  // nibble k (new[k] <- old[PERM[k]]). Nibble 0 is the most significant.
  // The inverse table undoes the forward one exactly.
  localparam logic [0:FUT_NIB-1][3:0] FUT_FWD_SR_PERM = {
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  localparam logic [0:FUT_NIB-1][3:0] FUT_INV_SR_PERM = {
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  // Rotate right by 16: the low 16 bits (indices 48..63) wrap to the top.
  function automatic logic [0:FUT_W-1] fut_ror16(input logic [0:FUT_W-1] x);
    return {x[48:63], x[0:47]};
  endfunction

  // Rotate right by 5: the low 5 bits (indices 59..63) wrap to the top.
  // This is also one backwards step of the key schedule.
  function automatic logic [0:FUT_W-1] fut_ror5(input logic [0:FUT_W-1] x);
    return {x[59:63], x[0:58]};
  endfunction

endpackage

// File: rtl/fut_inv_state_reg_if.sv
// Command/data bundle between the decryption round controller (master)
// and the inverse state register (slave).
interface fut_inv_state_reg_if #(
  parameter int CNT_W = 5
);
  import fut_pkg::*;

  logic               en;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [CNT_W-1:0]   cmd_cnt;
  logic [0:FUT_W-1]   din;
  logic [0:FUT_W-1]   dout;
  logic               done;

  modport master (
    output en, cmd_valid, cmd_op, cmd_cnt, din,
    input  cmd_ready, dout, done
  );

  modport slave (
    input  en, cmd_valid, cmd_op, cmd_cnt, din,
    output cmd_ready, dout, done
  );

endinterface

// File: rtl/fut_inv_shift_rows.sv
// Purely combinational 64-bit nibble permutation. Defaults to inverse
// ShiftRows; passing the forward table gives the encrypt-side permutation,
// so the same block can be dropped into an unrolled round datapath.
module fut_inv_shift_rows
  import fut_pkg::*;
#(
  parameter logic [0:FUT_NIB-1][3:0] PERM = FUT_INV_SR_PERM
) (
  input  logic [0:FUT_W-1] din,
  output logic [0:FUT_W-1] dout
);

  // Each output nibble is a straight wire from its source nibble.
  for (genvar k = 0; k < FUT_NIB; k++) begin : g_nib
    assign dout[4*k +: 4] = din[4*PERM[k] +: 4];
  end

endmodule

// File: rtl/fut_inv_state_reg.sv
// Decryption-side 64-bit state/key register for the FUTURE cipher.
// Single-cycle commands (LOAD, ROR16, ROR5, INV_SR, NOP) complete on the
// accept edge; REWIND N walks the key back N schedule steps (one ROR5 per
// enabled cycle) in BUSY. Every completion raises a registered done pulse.
// Dropping en freezes everything, including a pending done.
module fut_inv_state_reg
  import fut_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  fut_inv_state_reg_if.slave  bus
);

  logic [0:FUT_W-1]  dout_r;
  logic [0:FUT_W-1]  dout_nxt_s;
  logic [0:FUT_W-1]  inv_sr_s;
  fut_state_e        state_r;
  fut_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              cmd_ready_s;
  logic              accept_s;

  fut_inv_shift_rows #(
    .PERM (FUT_INV_SR_PERM)
  ) u_inv_sr (
    .din  (dout_r),
    .dout (inv_sr_s)
  );

  // Handshake: ready only while enabled and idle; no queueing while busy.
  always_comb begin
    cmd_ready_s = bus.en && (state_r == ST_IDLE);
    accept_s    = bus.cmd_valid && cmd_ready_s;
  end

  // Next-state, datapath and completion logic; holds everything when en is low.
  always_comb begin
    dout_nxt_s  = dout_r;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = done_r;

    if (bus.en) begin
      done_nxt_s = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            done_nxt_s = 1'b1;
            case (bus.cmd_op)
              OP_LOAD:   dout_nxt_s = bus.din;
              OP_ROR16:  dout_nxt_s = fut_ror16(dout_r);
              OP_ROR5:   dout_nxt_s = fut_ror5(dout_r);
              OP_INV_SR: dout_nxt_s = inv_sr_s;
              OP_REWIND: begin
                cnt_nxt_s = bus.cmd_cnt;
                // A zero-length rewind completes immediately, like a NOP.
                if (bus.cmd_cnt != {CNT_W{1'b0}}) begin
                  state_nxt_s = ST_BUSY;
                  done_nxt_s  = 1'b0;
                end else begin
                  state_nxt_s = ST_IDLE;
                end
              end
              default:   dout_nxt_s = dout_r;
            endcase
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          dout_nxt_s = fut_ror5(dout_r);
          cnt_nxt_s  = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      done_nxt_s = done_r;
    end
  end

  // State register, step counter, data register and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r  <= {FUT_W{1'b0}};
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      dout_r  <= dout_nxt_s;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.dout      = dout_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_fut_inv_state_reg.sv
// Self-checking bench for fut_inv_state_reg: directed steps from the test
// plan followed by randomized commands, all checked against a reference
// model of the register built from rotations and a nibble table.
module tb_fut_inv_state_reg;

  localparam int CNT_W = 5;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [63:0] model;
  logic [63:0] snap;
  int   cyc;

  fut_inv_state_reg_if #(.CNT_W(CNT_W)) bus ();

  fut_inv_state_reg #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate right by n (value view, MSB = nibble 0).
  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference: inverse ShiftRows from the new<-old nibble list.
  function automatic logic [63:0] m_inv_sr(input logic [63:0] x);
    int src [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    logic [3:0] nib [16];
    logic [63:0] r;
    for (int k = 0; k < 16; k++) nib[k] = x[63 - 4*k -: 4];
    r = 64'd0;
    for (int k = 0; k < 16; k++) r[63 - 4*k -: 4] = nib[src[k]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command with en high and check its completion against the model.
  task automatic run_cmd(input logic [2:0] op, input logic [63:0] data,
                         input int cnt, input bit rand_en, input string tag);
    int edges;
    int guard;
    bus.en        = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.din       = data;
    bus.cmd_cnt   = CNT_W'(cnt);
    chk({tag, ".ready_before"}, 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.din       = {$urandom, $urandom};
    case (op)
      3'd1:    model = data;
      3'd2:    model = m_ror(model, 16);
      3'd3:    model = m_ror(model, 5);
      3'd4:    model = m_inv_sr(model);
      default: model = model;
    endcase
    if (op == 3'd5 && cnt > 0) begin
      edges = 0;
      guard = 0;
      while (edges < cnt && guard < 200) begin
        chk({tag, ".busy_ready"}, 64'(bus.cmd_ready), 64'd0);
        chk({tag, ".busy_done"}, 64'(bus.done), 64'd0);
        chk({tag, ".busy_dout"}, bus.dout, model);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd1;
        bus.din       = {$urandom, $urandom};
        bus.en        = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick();
        if (bus.en) begin
          edges++;
          model = m_ror(model, 5);
        end
        guard++;
      end
      bus.cmd_valid = 1'b0;
      bus.en        = 1'b1;
      chk({tag, ".timeout"}, 64'(guard < 200), 64'd1);
    end
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".dout"}, bus.dout, model);
    chk({tag, ".ready_after"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model = 64'd0;
    rst_n = 1'b0;
    bus.en        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_cnt   = '0;
    bus.din       = 64'd0;

    // Reset state
    #12;
    chk("rst.dout", bus.dout, 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("rst.ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst.done_idle", 64'(bus.done), 64'd0);

    // LOAD, done is one cycle
    run_cmd(3'd1, 64'h0123456789ABCDEF, 0, 1'b0, "load");
    chk("load.const", bus.dout, 64'h0123456789ABCDEF);
    tick();
    chk("load.done_clear", 64'(bus.done), 64'd0);

    // INV_SR known answer and round trip of forward ShiftRows
    run_cmd(3'd4, 64'd0, 0, 1'b0, "invsr");
    chk("invsr.const", bus.dout, 64'h05AF49E38D27C16B);
    run_cmd(3'd1, 64'h0DA741EB852FC963, 0, 1'b0, "load2");
    run_cmd(3'd4, 64'd0, 0, 1'b0, "invsr_rt");
    chk("invsr_rt.const", bus.dout, 64'h0123456789ABCDEF);

    // ROR16 and ROR5 back to back
    run_cmd(3'd2, 64'd0, 0, 1'b0, "ror16");
    chk("ror16.const", bus.dout, 64'hCDEF0123456789AB);
    run_cmd(3'd1, 64'h0123456789ABCDEF, 0, 1'b0, "load3");
    run_cmd(3'd3, 64'd0, 0, 1'b0, "ror5");
    chk("ror5.const", bus.dout, 64'h78091A2B3C4D5E6F);

    // Reserved opcode behaves as NOP
    run_cmd(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, "rsvd");

    // REWIND 3: ready low exactly 3 cycles, single done at T+3
    run_cmd(3'd1, 64'h0123456789ABCDEF, 0, 1'b0, "load4");
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_cnt   = CNT_W'(3);
    tick();
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while (bus.cmd_ready == 1'b0 && cyc < 100) begin
      chk("rw3.no_early_done", 64'(bus.done), 64'd0);
      tick();
      cyc++;
    end
    model = m_ror(m_ror(m_ror(64'h0123456789ABCDEF, 5), 5), 5);
    chk("rw3.busy_cycles", 64'(cyc), 64'd3);
    chk("rw3.done", 64'(bus.done), 64'd1);
    chk("rw3.dout", bus.dout, model);
    tick();
    chk("rw3.done_single", 64'(bus.done), 64'd0);

    // REWIND 0 is a NOP
    run_cmd(3'd5, 64'd0, 0, 1'b0, "rw0");

    // REWIND 8 with en dropped for 4 cycles midway
    run_cmd(3'd1, 64'h0123456789ABCDEF, 0, 1'b0, "load5");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_cnt   = CNT_W'(8);
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick(); tick();
    snap = m_ror(m_ror(m_ror(64'h0123456789ABCDEF, 5), 5), 5);
    chk("rw8.mid", bus.dout, snap);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw8.frozen_dout", bus.dout, snap);
      chk("rw8.frozen_ready", 64'(bus.cmd_ready), 64'd0);
      chk("rw8.frozen_done", 64'(bus.done), 64'd0);
    end
    bus.en = 1'b1;
    cyc = 0;
    while (bus.cmd_ready == 1'b0 && cyc < 100) begin
      tick();
      cyc++;
    end
    model = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8; i++) model = m_ror(model, 5);
    chk("rw8.remaining", 64'(cyc), 64'd5);
    chk("rw8.dout", bus.dout, model);
    chk("rw8.done", 64'(bus.done), 64'd1);

    // done stretches while en is low
    run_cmd(3'd2, 64'd0, 0, 1'b0, "stretch");
    bus.en = 1'b0;
    tick(); tick();
    chk("stretch.done_held", 64'(bus.done), 64'd1);
    chk("stretch.ready_low", 64'(bus.cmd_ready), 64'd0);
    bus.en = 1'b1;
    tick();
    chk("stretch.done_clear", 64'(bus.done), 64'd0);

    // Async reset mid-REWIND
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_cnt   = CNT_W'(10);
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    model = 64'd0;
    chk("arst.dout", bus.dout, 64'd0);
    chk("arst.done", 64'(bus.done), 64'd0);
    chk("arst.ready", 64'(bus.cmd_ready), 64'd1);
    #3 rst_n = 1'b1;
    tick(); tick();
    chk("arst.no_done", 64'(bus.done), 64'd0);
    chk("arst.dout_hold", bus.dout, 64'd0);
    run_cmd(3'd1, 64'h1122334455667788, 0, 1'b0, "arst_load");

    // Randomized commands, including en gaps during REWIND
    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom_range(0, 7)), {$urandom, $urandom},
              $urandom_range(0, 6), 1'b1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
